// File: rtl/if_id_stage.sv
// IF/ID pipeline register for the 16-bit core.
// Tags fetched words with their PC and joins opcode+immediate pairs.
module if_id_stage #(
    parameter int W     = 16,
    parameter int PCW   = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     instr_in,
    input  logic [PCW-1:0]   pc_in,
    input  logic             stall,
    input  logic             flush,
    output logic [W-1:0]     out_instr,
    output logic [W-1:0]     out_imm,
    output logic [PCW-1:0]   out_pc,
    output logic             out_valid,
    output logic             out_has_imm,
    output logic             imm_pending,
    output logic [CNT_W-1:0] issued_cnt
);

    typedef enum logic {
        S_OP,
        S_IMM
    } state_t;

    state_t           state_q, state_d;
    logic [W-1:0]     op_q, op_d;
    logic [PCW-1:0]   hpc_q, hpc_d;
    logic [W-1:0]     instr_q, instr_d;
    logic [W-1:0]     imm_q, imm_d;
    logic [PCW-1:0]   pc_q, pc_d;
    logic             valid_q, valid_d;
    logic             has_imm_q, has_imm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             two_word;
    logic [CNT_W-1:0] cnt_inc;

    // Opcodes 12..15 share the top three bits 3'b011.
    assign two_word = (instr_in[15:13] == 3'b011);
    assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        hpc_d     = hpc_q;
        instr_d   = instr_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        valid_d   = valid_q;
        has_imm_d = has_imm_q;
        cnt_d     = cnt_q;
        if (flush) begin
            state_d   = S_OP;
            op_d      = '0;
            instr_d   = '0;
            imm_d     = '0;
            pc_d      = '0;
            valid_d   = 1'b0;
            has_imm_d = 1'b0;
        end else if (!stall) begin
            unique case (state_q)
                S_IMM: begin
                    instr_d   = op_q;
                    imm_d     = instr_in;
                    pc_d      = hpc_q;
                    valid_d   = 1'b1;
                    has_imm_d = 1'b1;
                    cnt_d     = cnt_inc;
                    state_d   = S_OP;
                end
                S_OP: begin
                    instr_d   = '0;
                    imm_d     = '0;
                    pc_d      = '0;
                    valid_d   = 1'b0;
                    has_imm_d = 1'b0;
                    if (two_word) begin
                        op_d    = instr_in;
                        hpc_d   = pc_in;
                        state_d = S_IMM;
                    end else if (instr_in == '0) begin
                        pc_d = pc_in;
                    end else begin
                        instr_d = instr_in;
                        pc_d    = pc_in;
                        valid_d = 1'b1;
                        cnt_d   = cnt_inc;
                    end
                end
                default: state_d = S_OP;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_OP;
            op_q      <= '0;
            hpc_q     <= '0;
            instr_q   <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            valid_q   <= 1'b0;
            has_imm_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            hpc_q     <= hpc_d;
            instr_q   <= instr_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            valid_q   <= valid_d;
            has_imm_q <= has_imm_d;
            cnt_q     <= cnt_d;
        end
    end

    assign out_instr   = instr_q;
    assign out_imm     = imm_q;
    assign out_pc      = pc_q;
    assign out_valid   = valid_q;
    assign out_has_imm = has_imm_q;
    assign imm_pending = (state_q == S_IMM);
    assign issued_cnt  = cnt_q;

endmodule

// File: tb/tb_if_id_stage.sv
// Randomized bench for if_id_stage against a behavioural packet model.
// A second instance with a 4-bit counter shares the stimulus.
module tb_if_id_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] instr_in = '0;
    logic [31:0] pc_in = '0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;

    logic [15:0] out_instr, out_imm, s_instr, s_imm;
    logic [31:0] out_pc, s_pc;
    logic        out_valid, out_has_imm, imm_pending;
    logic        s_valid, s_has_imm, s_pend;
    logic [15:0] issued_cnt;
    logic [3:0]  s_cnt;

    int errors = 0;
    int checks = 0;

    // model state
    bit          m_pend;
    logic [15:0] m_hop, m_instr, m_imm;
    logic [31:0] m_hpc, m_pc;
    bit          m_valid, m_has;
    int          m_cnt, m_cnt4;

    always #5 clk = ~clk;

    if_id_stage dut (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
        .stall(stall), .flush(flush), .out_instr(out_instr),
        .out_imm(out_imm), .out_pc(out_pc), .out_valid(out_valid),
        .out_has_imm(out_has_imm), .imm_pending(imm_pending),
        .issued_cnt(issued_cnt)
    );

    if_id_stage #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .instr_in(instr_in), .pc_in(pc_in),
        .stall(stall), .flush(flush), .out_instr(s_instr),
        .out_imm(s_imm), .out_pc(s_pc), .out_valid(s_valid),
        .out_has_imm(s_has_imm), .imm_pending(s_pend),
        .issued_cnt(s_cnt)
    );

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_pend = 0; m_hop = '0; m_hpc = '0;
        m_instr = '0; m_imm = '0; m_pc = '0;
        m_valid = 0; m_has = 0; m_cnt = 0; m_cnt4 = 0;
    endfunction

    function automatic void count();
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt4 < 15) m_cnt4++;
    endfunction

    function automatic void model_step(logic [15:0] w, logic [31:0] pc,
                                       bit st, bit fl);
        int op = int'(w[15:11]);
        if (fl) begin
            m_instr = '0; m_imm = '0; m_pc = '0;
            m_valid = 0; m_has = 0; m_pend = 0; m_hop = '0;
        end else if (st) begin
        end else if (m_pend) begin
            m_instr = m_hop; m_imm = w; m_pc = m_hpc;
            m_valid = 1; m_has = 1; m_pend = 0;
            count();
        end else if (op >= 12 && op <= 15) begin
            m_hop = w; m_hpc = pc; m_pend = 1;
            m_instr = '0; m_imm = '0; m_pc = '0;
            m_valid = 0; m_has = 0;
        end else begin
            m_imm = '0; m_has = 0; m_pc = pc;
            m_valid = (w != 0);
            m_instr = w;
            if (w != 0) count();
        end
    endfunction

    task automatic check_all(input string tag);
        chk({tag, ".instr"}, 64'(out_instr), 64'(m_instr));
        chk({tag, ".imm"}, 64'(out_imm), 64'(m_imm));
        chk({tag, ".pc"}, 64'(out_pc), 64'(m_pc));
        chk({tag, ".valid"}, 64'(out_valid), 64'(m_valid));
        chk({tag, ".has"}, 64'(out_has_imm), 64'(m_has));
        chk({tag, ".pend"}, 64'(imm_pending), 64'(m_pend));
        chk({tag, ".cnt"}, 64'(issued_cnt), 64'(m_cnt));
        chk({tag, ".cnt4"}, 64'(s_cnt), 64'(m_cnt4));
        chk({tag, ".pc4"}, 64'(s_pc), 64'(m_pc));
    endtask

    task automatic step(input logic [15:0] w, input logic [31:0] pc,
                        input bit st, input bit fl, input string tag);
        instr_in = w; pc_in = pc; stall = st; flush = fl;
        @(posedge clk);
        #1;
        model_step(w, pc, st, fl);
        check_all(tag);
    endtask

    initial begin
        logic [15:0] w;
        model_reset();
        #12;
        check_all("rst0");
        rst = 1'b1;
        @(posedge clk); #1;

        // async reset while an opcode waits for its immediate
        step(16'h6120, 32'h10, 0, 0, "pre");
        chk("pre.pending", 64'(imm_pending), 64'd1);
        #3 rst = 1'b0;
        #1;
        model_reset();
        check_all("arst");
        #3 rst = 1'b1;
        step(16'h0120, 32'h20, 0, 0, "r1");
        step(16'h0244, 32'h21, 0, 0, "r2");
        chk("r2.cnt2", 64'(issued_cnt), 64'd2);

        // two-word assembly
        step(16'h6120, 32'h30, 0, 0, "tw1");
        chk("tw1.bubble", 64'(out_valid), 64'd0);
        step(16'hBEEF, 32'h31, 0, 0, "tw2");
        chk("tw2.imm", 64'(out_imm), 64'hBEEF);
        chk("tw2.pc", 64'(out_pc), 64'h30);

        // stall holds a valid packet
        step(16'h0120, 32'h40, 0, 0, "st0");
        for (int i = 0; i < 3; i++)
            step(16'h0999, 32'h99, 1, 0, "stall");
        chk("stall.instr", 64'(out_instr), 64'h0120);
        step(16'h0344, 32'h41, 0, 0, "st1");

        // flush in S_IMM
        step(16'h6820, 32'h50, 0, 0, "fl0");
        step(16'h1234, 32'h51, 0, 1, "flush");
        chk("flush.pend", 64'(imm_pending), 64'd0);
        step(16'h0120, 32'h52, 0, 0, "fl1");
        chk("fl1.single", 64'(out_has_imm), 64'd0);

        // flush beats stall
        step(16'h0200, 32'h60, 0, 0, "fs0");
        step(16'h0300, 32'h61, 1, 1, "fs");
        chk("fs.valid", 64'(out_valid), 64'd0);

        // bubble in immediate slot still assembles
        step(16'h7000, 32'h70, 0, 0, "bi0");
        step(16'h0000, 32'h71, 0, 0, "bi1");

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(3))
                0: w = 16'h0000;
                1: w = {3'b011, 13'($urandom)};
                default: w = 16'($urandom);
            endcase
            step(w, $urandom, ($urandom_range(7) == 0),
                 ($urandom_range(9) == 0), "rnd");
        end

        // saturation of the 4-bit counter
        step(16'h0000, 32'h0, 0, 1, "satfl");
        for (int i = 0; i < 20; i++)
            step(16'h0120 + 16'(i), 32'h100 + i, 0, 0, "sat");
        chk("sat.cnt4", 64'(s_cnt), 64'd15);
        for (int i = 0; i < 3; i++)
            step(16'h0000, 32'h200 + i, 0, 0, "nop");
        chk("nop.valid", 64'(out_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/if_id_stage.md
Name: if_id_stage

Overview:
- Pipeline register between the instruction fetch memory and the decode/register-file stage of the 16-bit pipelined processor.
- Samples one fetched 16-bit word per cycle and tags it with its PC.
- Assembles two-word instructions (opcode word followed by a 16-bit immediate word) into a single decode packet.
- Applies stall and flush from the hazard/branch logic, and counts issued instructions.

Parameters:
- W, 16, instruction/immediate word width
- PCW, 32, program counter width
- CNT_W, 16, width of issued-instruction counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous reset, active-low (rst=0 resets immediately, independent of clk)
- instr_in  in  W  word from fetch; 16'h0000 = NOP/bubble
- pc_in  in  PCW  address of instr_in
- stall  in  1  hold all state and outputs this cycle
- flush  in  1  discard the in-flight word and any partially assembled instruction
- out_instr  out  W  opcode word to decode
- out_imm  out  W  immediate word; 0 when out_has_imm=0
- out_pc  out  PCW  PC of the opcode word
- out_valid  out  1  packet is a real instruction
- out_has_imm  out  1  out_imm is meaningful
- imm_pending  out  1  high while in S_IMM (an opcode is waiting for its immediate)
- issued_cnt  out  CNT_W  saturating count of packets emitted with out_valid=1

Behaviour:
- Instruction fields: opcode=[15:11], src=[10:8], dst=[7:5].
- Two-word opcodes: 5'd12 (LDM), 5'd13 (IADD), 5'd14 (SHL), 5'd15 (SHR). All other opcodes are single-word.
- Reset (rst=0, asynchronous):
  - state=S_OP; all outputs, the held opcode and held PC are cleared to 0.
  - Reset asserted mid-assembly discards the held opcode.
- Every output is a register. Latency is 1 cycle from instr_in to out_* for single-word instructions.
- The opcode of a two-word instruction appears 1 cycle after its immediate word.
- Priority each rising edge: flush > stall > normal.
- flush (in any state):
  - out_instr=0, out_imm=0, out_valid=0, out_has_imm=0, out_pc=0.
  - state=S_OP; held opcode cleared; issued_cnt unchanged.
- stall without flush: state, held opcode and all outputs hold their values; instr_in is ignored.
- S_OP, normal:
  - Word with a two-word opcode:
    - latch word and pc_in into the held registers; state=S_IMM.
    - emit a bubble (all outputs 0, out_valid=0).
  - instr_in==0: emit a bubble; out_pc=pc_in.
  - Otherwise:
    - out_instr=instr_in, out_pc=pc_in, out_imm=0, out_has_imm=0, out_valid=1.
    - issued_cnt += 1.
- S_IMM, normal:
  - Treat instr_in as the immediate, whatever its value, including 0.
  - out_instr=held opcode, out_imm=instr_in, out_pc=held PC, out_has_imm=1, out_valid=1.
  - issued_cnt += 1; state=S_OP.
- imm_pending=1 exactly while state==S_IMM.
- issued_cnt saturates at 2^CNT_W-1 and never wraps.
- A two-word opcode whose immediate slot is a bubble word is still assembled with imm=0. Fetch guarantees the immediate follows the opcode directly unless a flush intervenes.

Test Plan:
- Reset:
  - stimulus: rst=0 asynchronously mid-cycle with state S_IMM.
  - required: outputs 0 and imm_pending=0 immediately, before the next clk edge.
  - required: after release, words 16'h0120 at PC 0x20 and 16'h0244 at PC 0x21 appear in order on out_instr/out_pc, 1 cycle late each, out_valid=1, issued_cnt=2.
- Two-word:
  - stimulus: 16'h6120 (opcode 12) at PC 0x30, then 16'hBEEF.
  - required: cycle 1 emits a bubble with imm_pending=1.
  - required: cycle 2 emits out_instr=16'h6120, out_imm=16'hBEEF, out_pc=0x30, out_has_imm=1, out_valid=1.
- Stall:
  - stimulus: stall=1 for 3 cycles while a valid packet (16'h0120) is on the outputs.
  - required: outputs and issued_cnt frozen for those 3 cycles.
  - required: the next word is emitted 1 cycle after stall drops.
- Flush:
  - stimulus: flush=1 in S_IMM after 16'h6820.
  - required: next outputs are a bubble, imm_pending=0, issued_cnt unchanged.
  - required: the following word 16'h0120 issues as single-word.
- Flush+stall:
  - stimulus: both high together.
  - required: flush wins; outputs go to bubble.
- Saturation:
  - setup: CNT_W=4.
  - stimulus: 20 valid single-word instructions.
  - required: issued_cnt stops at 15.
  - stimulus: NOP words.
  - required: out_valid=0 and no count increment.
